// File: rtl/odd_operand_fetch.sv
// Odd-pipe register fetch / forwarding stage.
// Owns the 128 x 128-bit register file, resolves ra/rb/rc through the forwarding taps and
// write-back ports, stalls on RAW hazards against in-flight results, and registers one
// odd-pipe instruction per cycle.
module odd_operand_fetch #(
    parameter int unsigned FW_DEPTH = 7,
    parameter int unsigned NUM_REGS = 128
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [0:10]                 in_op_code,
    input  logic [2:0]                  in_instr_format,
    input  logic [1:0]                  in_unit,
    input  logic [0:6]                  in_dest_reg_addr,
    input  logic [0:6]                  in_ra_addr,
    input  logic [0:6]                  in_rb_addr,
    input  logic [0:6]                  in_rc_addr,
    input  logic                        in_ra_used,
    input  logic                        in_rb_used,
    input  logic                        in_rc_used,
    input  logic [0:17]                 in_imm_value,
    input  logic                        in_enable_reg_write,
    input  logic [7:0]                  in_program_counter,
    input  logic                        in_initial,
    input  logic                        flush,
    output logic                        stall,
    input  logic [FW_DEPTH-1:0][0:127]  odd_fw_data,
    input  logic [FW_DEPTH-1:0][0:6]    odd_fw_addr,
    input  logic [FW_DEPTH-1:0]         odd_fw_write,
    input  logic [FW_DEPTH-1:0][0:127]  even_fw_data,
    input  logic [FW_DEPTH-1:0][0:6]    even_fw_addr,
    input  logic [FW_DEPTH-1:0]         even_fw_write,
    input  logic [0:127]                odd_wb_data,
    input  logic [0:6]                  odd_wb_reg_addr,
    input  logic                        odd_wb_enable_reg_write,
    input  logic [0:127]                even_wb_data,
    input  logic [0:6]                  even_wb_reg_addr,
    input  logic                        even_wb_enable_reg_write,
    input  logic [9:0][0:6]             odd_pend_addr,
    input  logic [9:0]                  odd_pend_write,
    input  logic [6:0][0:6]             even_pend_addr,
    input  logic [6:0]                  even_pend_write,
    output logic [0:10]                 op_code,
    output logic [2:0]                  instr_format,
    output logic [1:0]                  unit,
    output logic [0:6]                  dest_reg_addr,
    output logic [0:17]                 imm_value,
    output logic                        enable_reg_write,
    output logic [7:0]                  program_counter_input,
    output logic                        initial_,
    output logic [0:127]                src_reg_a,
    output logic [0:127]                src_reg_b,
    output logic [0:127]                store_reg
);

    logic [0:127] reg_file [NUM_REGS];
    logic [0:127] res_a, res_b, res_c;
    logic         hazard;
    logic         issue;

    // Priority search: odd_fw[0], even_fw[0], odd_fw[1], ... then odd_wb, even_wb, then file.
    function automatic logic [0:127] resolve(
        input logic [0:6]                 addr,
        input logic [0:127]               file_val,
        input logic [FW_DEPTH-1:0][0:127] o_d,
        input logic [FW_DEPTH-1:0][0:6]   o_a,
        input logic [FW_DEPTH-1:0]        o_w,
        input logic [FW_DEPTH-1:0][0:127] e_d,
        input logic [FW_DEPTH-1:0][0:6]   e_a,
        input logic [FW_DEPTH-1:0]        e_w,
        input logic [0:127]               owb_d,
        input logic [0:6]                 owb_a,
        input logic                       owb_w,
        input logic [0:127]               ewb_d,
        input logic [0:6]                 ewb_a,
        input logic                       ewb_w
    );
        logic [0:127] val;
        logic         hit;
        val = file_val;
        hit = 1'b0;
        for (int i = 0; i < int'(FW_DEPTH); i++) begin
            if (!hit && o_w[i] && (o_a[i] == addr)) begin
                val = o_d[i];
                hit = 1'b1;
            end
            if (!hit && e_w[i] && (e_a[i] == addr)) begin
                val = e_d[i];
                hit = 1'b1;
            end
        end
        if (!hit && owb_w && (owb_a == addr)) begin
            val = owb_d;
            hit = 1'b1;
        end
        if (!hit && ewb_w && (ewb_a == addr)) begin
            val = ewb_d;
        end
        return val;
    endfunction

    // Register file: even write first so that odd write-back wins on an address collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                reg_file[i] <= '0;
            end
        end else begin
            if (even_wb_enable_reg_write) begin
                reg_file[even_wb_reg_addr] <= even_wb_data;
            end
            if (odd_wb_enable_reg_write) begin
                reg_file[odd_wb_reg_addr] <= odd_wb_data;
            end
        end
    end

    // Operand resolution for the three sources.
    always_comb begin
        res_a = resolve(in_ra_addr, reg_file[in_ra_addr], odd_fw_data, odd_fw_addr, odd_fw_write,
                        even_fw_data, even_fw_addr, even_fw_write, odd_wb_data, odd_wb_reg_addr,
                        odd_wb_enable_reg_write, even_wb_data, even_wb_reg_addr,
                        even_wb_enable_reg_write);
        res_b = resolve(in_rb_addr, reg_file[in_rb_addr], odd_fw_data, odd_fw_addr, odd_fw_write,
                        even_fw_data, even_fw_addr, even_fw_write, odd_wb_data, odd_wb_reg_addr,
                        odd_wb_enable_reg_write, even_wb_data, even_wb_reg_addr,
                        even_wb_enable_reg_write);
        res_c = resolve(in_rc_addr, reg_file[in_rc_addr], odd_fw_data, odd_fw_addr, odd_fw_write,
                        even_fw_data, even_fw_addr, even_fw_write, odd_wb_data, odd_wb_reg_addr,
                        odd_wb_enable_reg_write, even_wb_data, even_wb_reg_addr,
                        even_wb_enable_reg_write);
    end

    // RAW hazard: a used source matches an in-flight result that is not yet forwardable.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (odd_pend_write[i] &&
                ((in_ra_used && (odd_pend_addr[i] == in_ra_addr)) ||
                 (in_rb_used && (odd_pend_addr[i] == in_rb_addr)) ||
                 (in_rc_used && (odd_pend_addr[i] == in_rc_addr)))) begin
                hazard = 1'b1;
            end
        end
        for (int i = 0; i < 7; i++) begin
            if (even_pend_write[i] &&
                ((in_ra_used && (even_pend_addr[i] == in_ra_addr)) ||
                 (in_rb_used && (even_pend_addr[i] == in_rb_addr)) ||
                 (in_rc_used && (even_pend_addr[i] == in_rc_addr)))) begin
                hazard = 1'b1;
            end
        end
        // A flush discards the instruction, so it can never stall.
        stall = in_valid & ~flush & hazard;
        issue = in_valid & ~flush & ~hazard;
    end

    // Output register: load issued instruction, otherwise insert an all-zero bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_code               <= '0;
            instr_format          <= '0;
            unit                  <= '0;
            dest_reg_addr         <= '0;
            imm_value             <= '0;
            enable_reg_write      <= 1'b0;
            program_counter_input <= '0;
            initial_              <= 1'b0;
            src_reg_a             <= '0;
            src_reg_b             <= '0;
            store_reg             <= '0;
        end else if (issue) begin
            op_code               <= in_op_code;
            instr_format          <= in_instr_format;
            unit                  <= in_unit;
            dest_reg_addr         <= in_dest_reg_addr;
            imm_value             <= in_imm_value;
            enable_reg_write      <= in_enable_reg_write;
            program_counter_input <= in_program_counter;
            initial_              <= in_initial;
            src_reg_a             <= res_a;
            src_reg_b             <= res_b;
            store_reg             <= res_c;
        end else begin
            op_code               <= '0;
            instr_format          <= '0;
            unit                  <= '0;
            dest_reg_addr         <= '0;
            imm_value             <= '0;
            enable_reg_write      <= 1'b0;
            program_counter_input <= '0;
            initial_              <= 1'b0;
            src_reg_a             <= '0;
            src_reg_b             <= '0;
            store_reg             <= '0;
        end
    end

endmodule

// File: tb/tb_odd_operand_fetch.sv
// Self-checking bench for odd_operand_fetch: directed scenarios followed by randomized traffic,
// all compared against a behavioural register-file / forwarding model.
module tb_odd_operand_fetch;

    localparam int FW_DEPTH = 7;

    logic                        clock = 1'b0;
    logic                        reset;
    logic                        in_valid;
    logic [0:10]                 in_op_code;
    logic [2:0]                  in_instr_format;
    logic [1:0]                  in_unit;
    logic [0:6]                  in_dest_reg_addr;
    logic [0:6]                  in_ra_addr, in_rb_addr, in_rc_addr;
    logic                        in_ra_used, in_rb_used, in_rc_used;
    logic [0:17]                 in_imm_value;
    logic                        in_enable_reg_write;
    logic [7:0]                  in_program_counter;
    logic                        in_initial;
    logic                        flush;
    logic                        stall;
    logic [FW_DEPTH-1:0][0:127]  odd_fw_data, even_fw_data;
    logic [FW_DEPTH-1:0][0:6]    odd_fw_addr, even_fw_addr;
    logic [FW_DEPTH-1:0]         odd_fw_write, even_fw_write;
    logic [0:127]                odd_wb_data, even_wb_data;
    logic [0:6]                  odd_wb_reg_addr, even_wb_reg_addr;
    logic                        odd_wb_enable_reg_write, even_wb_enable_reg_write;
    logic [9:0][0:6]             odd_pend_addr;
    logic [9:0]                  odd_pend_write;
    logic [6:0][0:6]             even_pend_addr;
    logic [6:0]                  even_pend_write;
    logic [0:10]                 op_code;
    logic [2:0]                  instr_format;
    logic [1:0]                  unit;
    logic [0:6]                  dest_reg_addr;
    logic [0:17]                 imm_value;
    logic                        enable_reg_write;
    logic [7:0]                  program_counter_input;
    logic                        initial_;
    logic [0:127]                src_reg_a, src_reg_b, store_reg;

    int tests = 0;
    int fails = 0;

    logic [127:0] mreg [128];

    odd_operand_fetch dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_op_code(in_op_code),
        .in_instr_format(in_instr_format), .in_unit(in_unit),
        .in_dest_reg_addr(in_dest_reg_addr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_rc_addr(in_rc_addr), .in_ra_used(in_ra_used), .in_rb_used(in_rb_used),
        .in_rc_used(in_rc_used), .in_imm_value(in_imm_value),
        .in_enable_reg_write(in_enable_reg_write), .in_program_counter(in_program_counter),
        .in_initial(in_initial), .flush(flush), .stall(stall),
        .odd_fw_data(odd_fw_data), .odd_fw_addr(odd_fw_addr), .odd_fw_write(odd_fw_write),
        .even_fw_data(even_fw_data), .even_fw_addr(even_fw_addr), .even_fw_write(even_fw_write),
        .odd_wb_data(odd_wb_data), .odd_wb_reg_addr(odd_wb_reg_addr),
        .odd_wb_enable_reg_write(odd_wb_enable_reg_write),
        .even_wb_data(even_wb_data), .even_wb_reg_addr(even_wb_reg_addr),
        .even_wb_enable_reg_write(even_wb_enable_reg_write),
        .odd_pend_addr(odd_pend_addr), .odd_pend_write(odd_pend_write),
        .even_pend_addr(even_pend_addr), .even_pend_write(even_pend_write),
        .op_code(op_code), .instr_format(instr_format), .unit(unit),
        .dest_reg_addr(dest_reg_addr), .imm_value(imm_value),
        .enable_reg_write(enable_reg_write), .program_counter_input(program_counter_input),
        .initial_(initial_), .src_reg_a(src_reg_a), .src_reg_b(src_reg_b),
        .store_reg(store_reg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference operand: start from the file, then let each source overwrite in order of
    // increasing priority, so the youngest matching producer is what remains.
    function automatic logic [127:0] ref_operand(input logic [6:0] a);
        logic [127:0] v;
        v = mreg[a];
        if (even_wb_enable_reg_write && even_wb_reg_addr == a) v = even_wb_data;
        if (odd_wb_enable_reg_write && odd_wb_reg_addr == a) v = odd_wb_data;
        for (int i = FW_DEPTH - 1; i >= 0; i--) begin
            if (even_fw_write[i] && even_fw_addr[i] == a) v = even_fw_data[i];
            if (odd_fw_write[i] && odd_fw_addr[i] == a) v = odd_fw_data[i];
        end
        return v;
    endfunction

    function automatic logic ref_stall();
        int pend[$];
        logic hit;
        for (int i = 0; i < 10; i++) if (odd_pend_write[i]) pend.push_back(int'(odd_pend_addr[i]));
        for (int i = 0; i < 7; i++) if (even_pend_write[i]) pend.push_back(int'(even_pend_addr[i]));
        hit = 1'b0;
        foreach (pend[k]) begin
            if (in_ra_used && pend[k] == int'(in_ra_addr)) hit = 1'b1;
            if (in_rb_used && pend[k] == int'(in_rb_addr)) hit = 1'b1;
            if (in_rc_used && pend[k] == int'(in_rc_addr)) hit = 1'b1;
        end
        return in_valid && !flush && hit;
    endfunction

    task automatic clear_inputs();
        in_valid = 0; in_op_code = '0; in_instr_format = '0; in_unit = '0;
        in_dest_reg_addr = '0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
        in_ra_used = 0; in_rb_used = 0; in_rc_used = 0; in_imm_value = '0;
        in_enable_reg_write = 0; in_program_counter = '0; in_initial = 0; flush = 0;
        odd_fw_data = '0; odd_fw_addr = '0; odd_fw_write = '0;
        even_fw_data = '0; even_fw_addr = '0; even_fw_write = '0;
        odd_wb_data = '0; odd_wb_reg_addr = '0; odd_wb_enable_reg_write = 0;
        even_wb_data = '0; even_wb_reg_addr = '0; even_wb_enable_reg_write = 0;
        odd_pend_addr = '0; odd_pend_write = '0; even_pend_addr = '0; even_pend_write = '0;
    endtask

    task automatic rand_instr();
        in_valid = 1; in_op_code = 11'($urandom); in_instr_format = 3'($urandom);
        in_unit = 2'($urandom_range(0, 2)); in_dest_reg_addr = 7'($urandom);
        in_imm_value = 18'($urandom); in_enable_reg_write = 1'($urandom);
        in_program_counter = 8'($urandom); in_initial = 1'($urandom);
    endtask

    // One cycle: called just after a falling edge with inputs applied; returns at the next one.
    task automatic step(input string tag);
        logic [127:0] ea, eb, ec, ectl;
        logic         es, issue;
        #1;
        ea = ref_operand(in_ra_addr);
        eb = ref_operand(in_rb_addr);
        ec = ref_operand(in_rc_addr);
        es = ref_stall();
        chk({tag, ".stall"}, 128'(stall), 128'(es));
        issue = in_valid && !flush && !es && !reset;
        ectl = issue ? 128'({in_op_code, in_instr_format, in_unit, in_dest_reg_addr,
                             in_imm_value, in_enable_reg_write, in_program_counter,
                             in_initial}) : '0;
        @(posedge clock);
        if (reset) begin
            foreach (mreg[i]) mreg[i] = '0;
        end else begin
            if (even_wb_enable_reg_write) mreg[even_wb_reg_addr] = even_wb_data;
            if (odd_wb_enable_reg_write) mreg[odd_wb_reg_addr] = odd_wb_data;
        end
        #1;
        chk({tag, ".ctrl"}, 128'({op_code, instr_format, unit, dest_reg_addr, imm_value,
                                 enable_reg_write, program_counter_input, initial_}), ectl);
        chk({tag, ".src_a"}, src_reg_a, issue ? ea : '0);
        chk({tag, ".src_b"}, src_reg_b, issue ? eb : '0);
        chk({tag, ".store"}, store_reg, issue ? ec : '0);
        @(negedge clock);
    endtask

    initial begin
        foreach (mreg[i]) mreg[i] = '0;
        clear_inputs();
        reset = 1;
        @(negedge clock);
        step("reset");
        reset = 0;

        // Write-back r5, then read it through the file.
        odd_wb_enable_reg_write = 1; odd_wb_reg_addr = 5; odd_wb_data = {32{4'hA}};
        step("wb5");
        clear_inputs(); rand_instr(); in_ra_addr = 5; in_ra_used = 1;
        step("rd5");
        chk("rd5.value", src_reg_a, {32{4'hA}});

        // Forwarding priority: even_fw[0] beats odd_fw[2] and the file.
        clear_inputs(); odd_wb_enable_reg_write = 1; odd_wb_reg_addr = 9; odd_wb_data = 128'd3;
        step("wb9");
        clear_inputs(); rand_instr(); in_rb_addr = 9; in_rb_used = 1;
        odd_fw_write[2] = 1; odd_fw_addr[2] = 9; odd_fw_data[2] = 128'd1;
        even_fw_write[0] = 1; even_fw_addr[0] = 9; even_fw_data[0] = 128'd2;
        step("fwprio");
        chk("fwprio.value", src_reg_b, 128'd2);

        // Hazard on rc, then release.
        clear_inputs(); even_wb_enable_reg_write = 1; even_wb_reg_addr = 12;
        even_wb_data = 128'h1234_5678;
        step("wb12");
        clear_inputs(); rand_instr(); in_enable_reg_write = 1; in_rc_addr = 12; in_rc_used = 1;
        odd_pend_addr[3] = 12; odd_pend_write[3] = 1;
        step("haz");
        chk("haz.bubble_we", 128'(enable_reg_write), 128'd0);
        odd_pend_write = '0;
        step("haz_rel");
        chk("haz_rel.store", store_reg, 128'h1234_5678);

        // Same pend, but rc unused: no stall.
        odd_pend_write[3] = 1; in_rc_used = 0;
        step("unused");
        chk("unused.we", 128'(enable_reg_write), 128'd1);

        // Both write-backs hit r20: odd value survives in the file.
        clear_inputs(); odd_wb_enable_reg_write = 1; odd_wb_reg_addr = 20; odd_wb_data = 128'd1;
        even_wb_enable_reg_write = 1; even_wb_reg_addr = 20; even_wb_data = 128'd2;
        step("wb20");
        clear_inputs(); rand_instr(); in_ra_addr = 20; in_ra_used = 1;
        step("rd20");
        chk("rd20.value", src_reg_a, 128'd1);

        // Flush overrides a pending hazard.
        clear_inputs(); rand_instr(); in_enable_reg_write = 1; in_ra_addr = 20; in_ra_used = 1;
        even_pend_addr[6] = 20; even_pend_write[6] = 1; flush = 1;
        step("flush");
        chk("flush.we", 128'(enable_reg_write), 128'd0);

        // Randomized traffic on a narrow address range to provoke matches.
        for (int n = 0; n < 300; n++) begin
            clear_inputs();
            if ($urandom_range(0, 3) != 0) rand_instr();
            in_ra_addr = 7'($urandom_range(0, 15)); in_ra_used = 1'($urandom);
            in_rb_addr = 7'($urandom_range(0, 15)); in_rb_used = 1'($urandom);
            in_rc_addr = 7'($urandom_range(0, 15)); in_rc_used = 1'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < FW_DEPTH; i++) begin
                odd_fw_write[i] = ($urandom_range(0, 3) == 0);
                odd_fw_addr[i] = 7'($urandom_range(0, 15)); odd_fw_data[i] = rnd128();
                even_fw_write[i] = ($urandom_range(0, 3) == 0);
                even_fw_addr[i] = 7'($urandom_range(0, 15)); even_fw_data[i] = rnd128();
            end
            odd_wb_enable_reg_write = 1'($urandom); odd_wb_reg_addr = 7'($urandom_range(0, 15));
            odd_wb_data = rnd128();
            even_wb_enable_reg_write = 1'($urandom);
            even_wb_reg_addr = 7'($urandom_range(0, 15)); even_wb_data = rnd128();
            for (int i = 0; i < 10; i++) begin
                odd_pend_write[i] = ($urandom_range(0, 15) == 0);
                odd_pend_addr[i] = 7'($urandom_range(0, 15));
            end
            for (int i = 0; i < 7; i++) begin
                even_pend_write[i] = ($urandom_range(0, 15) == 0);
                even_pend_addr[i] = 7'($urandom_range(0, 15));
            end
            step("rand");
        end

        // Asynchronous reset in the middle of a stalled cycle.
        clear_inputs(); odd_wb_enable_reg_write = 1; odd_wb_reg_addr = 7; odd_wb_data = '1;
        step("wb7");
        clear_inputs(); rand_instr(); in_enable_reg_write = 1; in_ra_addr = 7; in_ra_used = 1;
        step("rd7");
        odd_pend_addr[0] = 7; odd_pend_write[0] = 1;
        #1;
        chk("mid.stall_before", 128'(stall), 128'd1);
        #1 reset = 1;
        foreach (mreg[i]) mreg[i] = '0;
        #1;
        chk("mid.async_we", 128'(enable_reg_write), 128'd0);
        chk("mid.async_src_a", src_reg_a, 128'd0);
        chk("mid.stall_held", 128'(stall), 128'd1);
        odd_pend_write = '0;
        #1;
        chk("mid.stall_drop", 128'(stall), 128'd0);
        @(negedge clock);
        reset = 0;
        step("rd7_after_reset");
        chk("rd7_after_reset.value", src_reg_a, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
